// File: rtl/cpu_pkg.sv
// Shared definitions for the processor front end: opcodes, fetch states and
// instruction field positions.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 8;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 24;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    localparam logic [OPC_W-1:0] OP_RTYPE = 8'h29;
    localparam logic [OPC_W-1:0] OP_LW    = 8'h2A;
    localparam logic [OPC_W-1:0] OP_SW    = 8'h2B;
    localparam logic [OPC_W-1:0] OP_BEQ   = 8'h2C;
    localparam logic [OPC_W-1:0] OP_BNE   = 8'h2D;
    localparam logic [OPC_W-1:0] OP_ADDI  = 8'h2E;
    localparam logic [OPC_W-1:0] OP_J     = 8'h2F;
    localparam logic [OPC_W-1:0] OP_JALFOR = 8'h30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // Defined opcodes form one contiguous range
    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        return (op >= OP_RTYPE) && (op <= OP_JALFOR);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump target, taken beq/bne relative target, or pc+1.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] ir,
    input  logic               jump,
    input  logic               branch,
    input  logic               alu_zero,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [ADDR_W-1:0] seq_pc;
    logic [31:0]       imm_sext;
    logic              taken;
    logic              unused_ir_bits;

    assign seq_pc   = pc + ADDR_W'(1);
    assign imm_sext = {{16{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
    // Opcode bit 0 separates bne (1) from beq (0)
    assign taken    = branch & (ir[OPC_LO] ? ~alu_zero : alu_zero);
    assign unused_ir_bits = ^ir;

    always_comb begin
        next_pc = seq_pc;
        if (jump) begin
            next_pc = ir[ADDR_W-1:0];
        end else if (taken) begin
            next_pc = seq_pc + ADDR_W'(imm_sext);
        end
    end

endmodule

// File: rtl/instr_fetch_issue.sv
// Processor front end: PC, instruction fetch over a ready handshake, single
// instruction issue, next-PC selection and jalfor link generation.
module instr_fetch_issue
    import cpu_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [OPC_W-1:0]   opcode,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ack,
    input  logic               branch,
    input  logic               jump,
    input  logic               jalfor,
    input  logic               alu_zero,
    output logic               link_valid,
    output logic [ADDR_W-1:0]  link_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic               illegal
);

    fetch_state_t       state, state_next;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  next_pc;
    logic               fetch_done;
    logic               halt_now;
    logic               ack_now;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pc       (pc),
        .ir       (ir),
        .jump     (jump),
        .branch   (branch),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    // Fetch/issue sequencing
    always_comb begin
        state_next = state;
        fetch_done = 1'b0;
        halt_now   = 1'b0;
        ack_now    = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    fetch_done = 1'b1;
                    if (!is_legal_op(imem_rdata[OPC_HI:OPC_LO])) begin
                        halt_now   = 1'b1;
                        state_next = S_HALT;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (instr_ack) begin
                    ack_now    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Handshake flags are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            ir          <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            link_valid  <= 1'b0;
            link_addr   <= '0;
            illegal     <= 1'b0;
        end else begin
            imem_req    <= (state_next == S_FETCH);
            instr_valid <= (state_next == S_ISSUE);
            link_valid  <= ack_now & jalfor;
            if (fetch_done) ir <= imem_rdata;
            if (halt_now) illegal <= 1'b1;
            if (ack_now) pc <= next_pc;
            if (ack_now && jalfor) link_addr <= pc + ADDR_W'(1);
        end
    end

    assign imem_addr = pc;
    assign opcode    = ir[OPC_HI:OPC_LO];
    assign instr     = ir;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: memory and datapath responders,
// a per-cycle reference model and directed scenarios.
module tb_instr_fetch_issue;
    import cpu_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_ISSUE = 2;
    localparam int P_HALT  = 3;

    logic              clk = 1'b0;
    logic              reset, run;
    logic              imem_req, imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [7:0]        opcode;
    logic [31:0]       instr;
    logic              instr_valid, instr_ack;
    logic              branch, jump, jalfor, alu_zero;
    logic              link_valid;
    logic [ADDR_W-1:0] link_addr, pc;
    logic              illegal;

    instr_fetch_issue #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .opcode(opcode), .instr(instr), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .branch(branch), .jump(jump),
        .jalfor(jalfor), .alu_zero(alu_zero),
        .link_valid(link_valid), .link_addr(link_addr),
        .pc(pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          rdelay, adelay, rcnt, acnt;
    bit          zq[$];
    int          tests = 0, fails = 0;

    int          phase, exp_pc, exp_link_addr;
    logic [31:0] exp_ir;
    bit          exp_illegal, exp_link, prev_valid;
    int          fetch_log[$];
    int          link_log[$];
    logic [7:0]  op_log[$];
    int          link_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Instruction memory: ready after rdelay waiting cycles of a request
    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        rcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (reset || !imem_req || imem_ready) begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
                rcnt = 0;
            end else if (rcnt >= rdelay) begin
                imem_ready = 1'b1;
                imem_rdata = mem[imem_addr];
                rcnt = 0;
            end else begin
                rcnt++;
            end
        end
    end

    // Datapath and decoder: ack after adelay cycles with decoded control
    initial begin
        instr_ack = 1'b0; branch = 1'b0; jump = 1'b0; jalfor = 1'b0; alu_zero = 1'b0;
        acnt = 0;
        forever begin
            @(posedge clk); #1;
            if (reset || !instr_valid || instr_ack) begin
                instr_ack = 1'b0;
                branch = 1'($urandom); jump = 1'($urandom);
                jalfor = 1'($urandom); alu_zero = 1'($urandom);
                acnt = 0;
            end else if (acnt >= adelay) begin
                instr_ack = 1'b1;
                branch = (instr[31:24] == OP_BEQ) || (instr[31:24] == OP_BNE);
                jump   = (instr[31:24] == OP_J) || (instr[31:24] == OP_JALFOR);
                jalfor = (instr[31:24] == OP_JALFOR);
                alu_zero = (branch && zq.size() > 0) ? zq.pop_front() : 1'b0;
                acnt = 0;
            end else begin
                instr_ack = 1'b0;
                branch = 1'($urandom); jump = 1'($urandom);
                jalfor = 1'($urandom); alu_zero = 1'($urandom);
                acnt++;
            end
        end
    end

    // Reference model: compare this cycle, then step to what the next edge must produce
    always @(negedge clk) begin : model
        int off, npc;
        bit tk;
        if (reset) begin
            phase = P_IDLE; exp_pc = 0; exp_ir = '0;
            exp_illegal = 1'b0; exp_link = 1'b0; exp_link_addr = 0;
        end
        check("pc", 32'(pc), 32'(exp_pc));
        check("imem_req", 32'(imem_req), 32'(phase == P_FETCH));
        if (phase == P_FETCH) check("imem_addr", 32'(imem_addr), 32'(exp_pc));
        check("instr_valid", 32'(instr_valid), 32'(phase == P_ISSUE));
        check("instr", instr, exp_ir);
        check("opcode", 32'(opcode), 32'(exp_ir[31:24]));
        check("illegal", 32'(illegal), 32'(exp_illegal));
        check("link_valid", 32'(link_valid), 32'(exp_link));
        if (exp_link) check("link_addr", 32'(link_addr), 32'(exp_link_addr));

        if (link_valid) begin link_cnt++; link_log.push_back(int'(link_addr)); end
        if (instr_valid && !prev_valid) op_log.push_back(opcode);
        prev_valid = instr_valid;

        if (!reset) begin
            exp_link = 1'b0;
            case (phase)
                P_IDLE: if (run) phase = P_FETCH;
                P_FETCH: if (imem_ready) begin
                    fetch_log.push_back(exp_pc);
                    exp_ir = imem_rdata;
                    if (imem_rdata[31:24] < 8'h29 || imem_rdata[31:24] > 8'h30) begin
                        phase = P_HALT;
                        exp_illegal = 1'b1;
                    end else begin
                        phase = P_ISSUE;
                    end
                end
                P_ISSUE: if (instr_ack) begin
                    off = exp_ir[15] ? int'(exp_ir[15:0]) - 65536 : int'(exp_ir[15:0]);
                    tk = branch && ((!exp_ir[24] && alu_zero) || (exp_ir[24] && !alu_zero));
                    if (jump)    npc = int'(exp_ir[7:0]);
                    else if (tk) npc = (exp_pc + 1 + off) & 255;
                    else         npc = (exp_pc + 1) & 255;
                    if (jalfor) begin
                        exp_link = 1'b1;
                        exp_link_addr = (exp_pc + 1) & 255;
                    end
                    exp_pc = npc;
                    phase = P_FETCH;
                end
                default: ;
            endcase
        end
    end

    task automatic wait_fetches(input int n, input int budget);
        int c = 0;
        while (fetch_log.size() < n && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        check("fetch_count_timeout", 32'(fetch_log.size() >= n), 32'd1);
    endtask

    task automatic pulse_run();
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int exp1[12] = '{0, 1, 2, 5, 4, 5, 6, 16, 64, 128, 255, 0};
        int exp2[3]  = '{0, 5, 9};
        int c;
        reset = 1'b1; run = 1'b0; rdelay = 1; adelay = 1; link_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h2900_0000;
        mem[1] = 32'h2E00_0005; mem[2] = 32'h2F00_0005; mem[5] = 32'h2C00_FFFE;
        mem[4] = 32'h2F00_0005; mem[6] = 32'h2F00_0010; mem[16] = 32'h3000_0040;
        mem[64] = 32'h2F00_0080; mem[128] = 32'h2F00_00FF; mem[255] = 32'h2E00_0000;
        zq = '{1'b1, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_link_valid", 32'(link_valid), 32'd0);
        check("rst_link_addr", 32'(link_addr), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", instr, 32'd0);

        // Sequential flow, branches, jump/link and wrap-around
        @(posedge clk); #1 reset = 1'b0;
        pulse_run();
        wait_fetches(12, 600);
        for (int i = 0; i < 12; i++)
            if (i < fetch_log.size()) check("p1_fetch_addr", 32'(fetch_log[i]), 32'(exp1[i]));
        if (op_log.size() >= 2) begin
            check("p1_first_opcode", 32'(op_log[0]), 32'h29);
            check("p1_second_opcode", 32'(op_log[1]), 32'h2E);
        end else check("p1_opcode_log", 32'(op_log.size()), 32'd2);
        check("p1_link_pulses", 32'(link_cnt), 32'd1);
        if (link_log.size() > 0) check("p1_link_addr", 32'(link_log[0]), 32'h11);

        // bne with stalls, then illegal opcode halts
        @(posedge clk); #1 reset = 1'b1;
        mem[0] = 32'h2F00_0005; mem[5] = 32'h2D00_0003; mem[9] = 32'h3100_0000;
        zq = '{1'b0}; rdelay = 5; adelay = 7;
        fetch_log.delete(); link_cnt = 0;
        @(posedge clk); #1 reset = 1'b0;
        pulse_run();
        c = 0;
        while (!illegal && c < 300) begin @(negedge clk); #1; c++; end
        repeat (10) @(negedge clk);
        #1;
        check("p2_illegal", 32'(illegal), 32'd1);
        check("p2_no_req", 32'(imem_req), 32'd0);
        check("p2_no_valid", 32'(instr_valid), 32'd0);
        check("p2_fetch_count", 32'(fetch_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < fetch_log.size()) check("p2_fetch_addr", 32'(fetch_log[i]), 32'(exp2[i]));
        check("p2_link_pulses", 32'(link_cnt), 32'd0);

        // Reset clears the halt
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); #1;
        check("p2_rst_illegal", 32'(illegal), 32'd0);
        check("p2_rst_pc", 32'(pc), 32'd0);

        // Async reset in the middle of a fetch
        rdelay = 3;
        @(posedge clk); #1 reset = 1'b0;
        pulse_run();
        c = 0;
        while (!imem_req && c < 20) begin @(negedge clk); #1; c++; end
        @(posedge clk); #2;
        check("p3_req_before_reset", 32'(imem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("p3_async_req", 32'(imem_req), 32'd0);
        check("p3_async_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("p3_idle_req", 32'(imem_req), 32'd0);
        check("p3_idle_valid", 32'(instr_valid), 32'd0);
        check("p3_idle_pc", 32'(pc), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Front end of the single-issue processor: holds the PC and fetches 32-bit instruction words from instruction memory over a ready handshake.
- Presents the opcode byte to the control decoder and issues one instruction at a time to the datapath.
- Consumes the decoder's branch/jump/jalfor results plus the ALU zero flag to select the next PC, and generates the jalfor link address.
- It is the producer end of the decoder's opcode interface and the consumer of its redirect outputs.

Parameters:
- ADDR_W, 8, instruction word-address width; PC arithmetic wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  fetch enable; sampled only in S_IDLE.
- imem_req  output  1  instruction read request.
- imem_addr  output  ADDR_W  read word address (= pc).
- imem_ready  input  1  rdata valid this cycle; ends the request.
- imem_rdata  input  32  instruction word.
- opcode  output  8  ir[31:24], to control decoder.
- instr  output  32  full instruction register.
- instr_valid  output  1  instruction issued, awaiting ack.
- instr_ack  input  1  datapath accepts; branch/jump/jalfor/alu_zero valid this cycle.
- branch  input  1  from decoder.
- jump  input  1  from decoder.
- jalfor  input  1  from decoder.
- alu_zero  input  1  ALU zero flag for the issued instruction.
- link_valid  output  1  one-cycle pulse: link_addr must be written to the register file.
- link_addr  output  ADDR_W  pc+1 of the jalfor instruction.
- pc  output  ADDR_W  current PC.
- illegal  output  1  sticky; set by an undefined opcode.

Behaviour:
- Reset (async, asynchronous assert): pc=RESET_PC, ir=0, state=S_IDLE. All of imem_req, instr_valid, link_valid and illegal are 0; link_addr=0.
- Legal opcodes: 0x29 rtype, 0x2A lw, 0x2B sw, 0x2C beq, 0x2D bne, 0x2E addi, 0x2F j, 0x30 jalfor. Any other value is illegal.
- S_IDLE: all outputs inactive. If run=1, go to S_FETCH next cycle.
- S_FETCH:
  - imem_req=1 and imem_addr=pc; both held stable until imem_ready.
  - On imem_ready: ir<=imem_rdata.
  - If imem_rdata[31:24] is illegal: illegal<=1, go to S_HALT.
  - Otherwise go to S_ISSUE.
  - Minimum latency from ready to issue is 1 cycle.
- S_ISSUE:
  - instr_valid=1; opcode and instr stable.
  - Waits indefinitely for instr_ack, which is ignored in all other states.
  - On instr_ack, the next PC is chosen by priority:
    1. jump=1: pc <= ir[ADDR_W-1:0].
    2. branch=1 and taken: pc <= pc+1+sext(ir[15:0]), truncated to ADDR_W. Taken means (opcode[0]=0 and alu_zero=1) for beq, or (opcode[0]=1 and alu_zero=0) for bne.
    3. Otherwise: pc <= pc+1.
  - If jalfor=1 on ack: link_addr <= pc+1 (pre-update pc) and link_valid=1 for exactly the following cycle.
  - Go to S_FETCH; the next request starts the cycle after ack.
- S_HALT: no requests, instr_valid=0, illegal=1. Exit only via reset.
- Wrap-around: pc=2^ADDR_W-1 with sequential advance gives 0. Branch offsets are signed two's complement; a negative offset below 0 wraps modulo 2^ADDR_W.
- Simultaneous jump and branch: jump wins. jalfor without jump still produces the link, and pc follows rules 2/3.
- run deasserted outside S_IDLE has no effect; the run/stop decision is made only in S_IDLE.
- Reset mid-fetch: imem_req drops immediately (async). Any in-flight imem_ready after reset is ignored.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams OP_RTYPE..OP_JALFOR (0x29..0x30);
  - fetch state encoding S_IDLE, S_FETCH, S_ISSUE, S_HALT;
  - instruction field positions: opcode [31:24], imm [15:0], jump target [ADDR_W-1:0].
- One natural sub-module, next_pc_sel: combinational next-PC and branch-taken logic. Inputs are pc, ir, jump, branch, alu_zero; output is next_pc.
- The FSM, IR and link logic stay in the top.

Test Plan:
- Sequential flow: reset, run=1; memory holds 0x29000000 at addr 0 and 0x2E000005 at addr 1, imem_ready 1 cycle after req, ack 1 cycle after instr_valid → imem_addr 0, then 1, then 2; opcode shows 0x29, then 0x2E; link_valid never asserts.
- Branch: beq 0x2C00FFFE at pc=5 with branch=1. With alu_zero=1 → next pc=4. Repeat with alu_zero=0 → pc=6. bne 0x2D000003 at pc=5 with alu_zero=0 → pc=9.
- Jump and link: jalfor 0x30000040 at pc=0x10 with jump=1, jalfor=1 → pc=0x40; link_valid pulses exactly 1 cycle with link_addr=0x11. Plain j 0x2F000080 → pc=0x80 with no link pulse.
- Wrap and stalls: pc=0xFF sequential → next fetch at 0x00. imem_ready delayed 5 cycles → imem_req and imem_addr stable throughout. instr_ack delayed 7 cycles → instr_valid and opcode held stable.
- Illegal opcode: fetch word 0x31000000 → illegal=1, state S_HALT, no further imem_req, illegal stays 1. Reset clears it and pc returns to RESET_PC.
- Async reset: assert reset mid-S_FETCH, between clock edges → imem_req and instr_valid drop immediately. After release with run=0 → stays in S_IDLE with no requests.
